// File: rtl/fc_spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fc_spi_pkg
//  Brief    : Shared constants for the flight-computer SPI responder:
//             command codes, FSM state encoding and default word width.
//  Revision : 1.0 - initial release
// ============================================================================
package fc_spi_pkg;

   localparam int WORD_W_DEFAULT = 16;

   // Command codes carried in word0 of a frame
   localparam logic [15:0] CMD_WRITE   = 16'd2;
   localparam logic [15:0] CMD_READ    = 16'd3;
   localparam logic [15:0] CMD_SD_READ = 16'd5;

   // FSM state encoding; also exported on spi_state_p
   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CMD     = 3'd1;
   localparam state_t ST_ADDR    = 3'd2;
   localparam state_t ST_WR_DATA = 3'd3;
   localparam state_t ST_RD_DATA = 3'd4;
   localparam state_t ST_WAIT_SS = 3'd5;

endpackage
`default_nettype wire

// File: rtl/fc_spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fc_spi_sync_edge
//  Brief    : Multi-stage synchroniser for one asynchronous input, with
//             rise/fall pulses derived from the synchronised value.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Synchroniser chain plus one extra flop holding the previous value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_q    = r_sync[SYNC_STAGES-1];
   assign o_rise =  o_q & ~r_prev;
   assign o_fall = ~o_q &  r_prev;

endmodule
`default_nettype wire

// File: rtl/fc_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fc_spi_slave
//  Brief    : SPI mode-0 responder for the BBB master. Decodes
//             command/address/data frames into memory-map strobes, returns
//             read data on MISO and issues the SD-card read start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_spi_slave
   import fc_spi_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEFAULT,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk210_p,
   input  logic              reset_p,
   input  logic              fc_spi_sck_p,
   input  logic              fc_spi_mosi_p,
   input  logic              fc_spi_ss_p,
   output logic              fc_spi_miso_p,
   output logic [WORD_W-1:0] memory_map_spi_wr_addr_p,
   output logic [WORD_W-1:0] memory_map_spi_wr_data_p,
   output logic              memory_map_spi_wr_en_p,
   output logic [WORD_W-1:0] memory_map_spi_rd_addr_p,
   output logic              memory_map_spi_rd_en_p,
   input  logic [WORD_W-1:0] memory_map_spi_rd_data_p,
   output logic              sd_read_start_p,
   output logic              cmd_error_p,
   output logic [7:0]        spi_state_p
);

   localparam int               CNT_W    = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   // ------------------------------------------------------------------
   // Input synchronisation
   // ------------------------------------------------------------------
   logic w_sck_q, w_sck_rise, w_sck_fall;
   logic w_ss_q, w_ss_rise, w_ss_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_unused_sync;

   fc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .clk    (clk210_p),
      .rst_n  (reset_p),
      .i_d    (fc_spi_sck_p),
      .o_q    (w_sck_q),
      .o_rise (w_sck_rise),
      .o_fall (w_sck_fall)
   );

   fc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
      .clk    (clk210_p),
      .rst_n  (reset_p),
      .i_d    (fc_spi_ss_p),
      .o_q    (w_ss_q),
      .o_rise (w_ss_rise),
      .o_fall (w_ss_fall)
   );

   // mosi only needs the delay-matched level, its edge outputs are unused
   fc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk    (clk210_p),
      .rst_n  (reset_p),
      .i_d    (fc_spi_mosi_p),
      .o_q    (w_mosi),
      .o_rise (w_mosi_rise),
      .o_fall (w_mosi_fall)
   );

   assign w_unused_sync = w_sck_q | w_ss_q | w_mosi_rise | w_mosi_fall;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t                r_state;
   logic                  r_is_read;
   logic [CNT_W-1:0]      r_cnt;
   logic [WORD_W-1:0]     r_rx;
   logic [WORD_W-1:0]     r_tx;
   logic                  r_miso;
   logic                  r_wr_en, r_rd_en, r_sd_start, r_cmd_err;
   logic [WORD_W-1:0]     r_wr_addr, r_wr_data, r_rd_addr;
   logic [RD_LATENCY-1:0] r_rd_pipe;

   logic                  w_active;
   logic                  w_word_done;
   logic [WORD_W-1:0]     w_word;
   logic                  w_capture;

   state_t                w_next;
   logic                  w_is_read_next;
   logic                  w_wr_req, w_rd_req, w_sd_req, w_err_req;
   logic                  w_lat_waddr, w_lat_raddr;

   assign w_active    = (r_state == ST_CMD)     || (r_state == ST_ADDR) ||
                        (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA);
   // The word in flight including the bit sampled on this rise
   assign w_word      = {r_rx[WORD_W-2:0], w_mosi};
   assign w_word_done = w_active && w_sck_rise && (r_cnt == CNT_LAST);
   // rd_data is valid RD_LATENCY cycles after the rd_en pulse
   assign w_capture   = r_rd_pipe[RD_LATENCY-1];

   // Next-state and strobe-request decode; completion acts before an ss abort
   always_comb begin
      w_next         = r_state;
      w_is_read_next = r_is_read;
      w_wr_req       = 1'b0;
      w_rd_req       = 1'b0;
      w_sd_req       = 1'b0;
      w_err_req      = 1'b0;
      w_lat_waddr    = 1'b0;
      w_lat_raddr    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall) w_next = ST_CMD;
         end
         ST_CMD: begin
            if (w_word_done) begin
               if (w_word == WORD_W'(CMD_WRITE)) begin
                  w_is_read_next = 1'b0;
                  w_next         = ST_ADDR;
               end else if (w_word == WORD_W'(CMD_READ)) begin
                  w_is_read_next = 1'b1;
                  w_next         = ST_ADDR;
               end else if (w_word == WORD_W'(CMD_SD_READ)) begin
                  w_sd_req = 1'b1;
                  w_next   = ST_WAIT_SS;
               end else begin
                  w_err_req = 1'b1;
                  w_next    = ST_WAIT_SS;
               end
            end
         end
         ST_ADDR: begin
            if (w_word_done) begin
               if (r_is_read) begin
                  w_lat_raddr = 1'b1;
                  w_rd_req    = 1'b1;
                  w_next      = ST_RD_DATA;
               end else begin
                  w_lat_waddr = 1'b1;
                  w_next      = ST_WR_DATA;
               end
            end
         end
         ST_WR_DATA: begin
            if (w_word_done) begin
               w_wr_req = 1'b1;
               w_next   = ST_WAIT_SS;
            end
         end
         ST_RD_DATA: begin
            if (w_word_done) w_next = ST_WAIT_SS;
         end
         ST_WAIT_SS: begin
            if (w_ss_rise) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase

      // ss deasserted mid-frame: flag the abort unless a strobe already
      // went out this cycle, keeping the strobes mutually exclusive
      if (w_ss_rise && w_active) begin
         if ((w_next != ST_WAIT_SS) && !w_rd_req) w_err_req = 1'b1;
         w_next = ST_IDLE;
      end
   end

   // FSM state and read/write frame type
   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         r_state   <= ST_IDLE;
         r_is_read <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_is_read <= w_is_read_next;
      end
   end

   // Bit counter and MOSI deserialiser, cleared at frame start
   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         r_cnt <= '0;
         r_rx  <= '0;
      end else if ((r_state == ST_IDLE) && w_ss_fall) begin
         r_cnt <= '0;
      end else if (w_active && w_sck_rise) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
         r_rx  <= w_word;
      end
   end

   // Single-cycle strobes and held memory-map address/data
   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_sd_start <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rd_addr  <= '0;
      end else begin
         r_wr_en    <= w_wr_req;
         r_rd_en    <= w_rd_req;
         r_sd_start <= w_sd_req;
         r_cmd_err  <= w_err_req;
         if (w_lat_waddr) r_wr_addr <= w_word;
         if (w_wr_req)    r_wr_data <= w_word;
         if (w_lat_raddr) r_rd_addr <= w_word;
      end
   end

   // Read-latency pipeline and MISO shift register
   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         r_rd_pipe <= '0;
         r_tx      <= '0;
      end else begin
         r_rd_pipe[0] <= r_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
         end
         if (w_capture) begin
            r_tx <= memory_map_spi_rd_data_p;
         end else if ((r_state == ST_RD_DATA) && w_sck_fall) begin
            r_tx <= {r_tx[WORD_W-2:0], 1'b0};
         end
      end
   end

   // MISO bit presented on each sck fall while returning read data
   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         r_miso <= 1'b0;
      end else if (w_next != ST_RD_DATA) begin
         r_miso <= 1'b0;
      end else if ((r_state == ST_RD_DATA) && w_sck_fall) begin
         r_miso <= r_tx[WORD_W-1];
      end
   end

   // Raw ss gating keeps MISO quiet the moment the master deselects
   assign fc_spi_miso_p            = r_miso & ~fc_spi_ss_p;
   assign memory_map_spi_wr_addr_p = r_wr_addr;
   assign memory_map_spi_wr_data_p = r_wr_data;
   assign memory_map_spi_wr_en_p   = r_wr_en;
   assign memory_map_spi_rd_addr_p = r_rd_addr;
   assign memory_map_spi_rd_en_p   = r_rd_en;
   assign sd_read_start_p          = r_sd_start;
   assign cmd_error_p              = r_cmd_err;
   assign spi_state_p              = {{(8-STATE_W){1'b0}}, r_state};

endmodule
`default_nettype wire

// File: tb/tb_fc_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fc_spi_slave
//  Brief    : Directed SPI-master bench for fc_spi_slave with a frame-level
//             reference model and a single per-cycle compare process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_spi_slave;

   localparam int HALF = 8;   // sck half period in clk cycles

   logic        clk210_p = 1'b0;
   logic        reset_p;
   logic        fc_spi_sck_p;
   logic        fc_spi_mosi_p;
   logic        fc_spi_ss_p;
   logic        fc_spi_miso_p;
   logic [15:0] wr_addr, wr_data, rd_addr, rd_data;
   logic        wr_en, rd_en, sd_start, cmd_err;
   logic [7:0]  spi_state;

   always #5 clk210_p = ~clk210_p;

   fc_spi_slave #(.WORD_W(16), .RD_LATENCY(1), .SYNC_STAGES(2)) dut (
      .clk210_p                 (clk210_p),
      .reset_p                  (reset_p),
      .fc_spi_sck_p             (fc_spi_sck_p),
      .fc_spi_mosi_p            (fc_spi_mosi_p),
      .fc_spi_ss_p              (fc_spi_ss_p),
      .fc_spi_miso_p            (fc_spi_miso_p),
      .memory_map_spi_wr_addr_p (wr_addr),
      .memory_map_spi_wr_data_p (wr_data),
      .memory_map_spi_wr_en_p   (wr_en),
      .memory_map_spi_rd_addr_p (rd_addr),
      .memory_map_spi_rd_en_p   (rd_en),
      .memory_map_spi_rd_data_p (rd_data),
      .sd_read_start_p          (sd_start),
      .cmd_error_p              (cmd_err),
      .spi_state_p              (spi_state)
   );

   // Memory map model: registered read, one cycle latency
   logic [15:0] mem [0:255];
   always @(posedge clk210_p) begin
      if (rd_en) rd_data <= mem[rd_addr[7:0]];
   end

   // Expectations published by the stimulus process
   int          exp_wr, exp_rd, exp_sd, exp_err;
   logic [15:0] exp_wr_addr, exp_wr_data, exp_rd_addr, exp_rx;
   bit          exp_rx_valid;
   bit          quiet;              // miso must stay 0 for this frame
   logic [15:0] lit_rx, lit_wr_addr, lit_wr_data;
   bit          lit_rx_valid, lit_hold_valid;
   bit          timeout_flag;
   bit          done;
   int          chk_req;
   logic [15:0] rx_words [0:2];

   // Compare-process state
   int vectors = 0;
   int miscompares = 0;
   int n_wr = 0, n_rd = 0, n_sd = 0, n_err = 0;
   int b_wr = 0, b_rd = 0, b_sd = 0, b_err = 0;
   int chk_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Single compare process: per-cycle invariants, strobe payloads,
   // end-of-frame totals, and the summary
   always @(posedge clk210_p) begin
      int s;
      #1;
      s = int'(wr_en) + int'(rd_en) + int'(sd_start) + int'(cmd_err);
      check("strobe_exclusive", 64'(s > 1), 64'd0);
      if (!reset_p)
         check("reset_outputs",
               {4'd0, fc_spi_miso_p, wr_addr, wr_data, wr_en, rd_addr, rd_en,
                sd_start, cmd_err, spi_state}, 64'd0);
      if (fc_spi_ss_p || quiet)
         check("miso_quiet", 64'(fc_spi_miso_p), 64'd0);
      if (wr_en) begin
         n_wr++;
         check("wr_addr_at_strobe", 64'(wr_addr), 64'(exp_wr_addr));
         check("wr_data_at_strobe", 64'(wr_data), 64'(exp_wr_data));
      end
      if (rd_en) begin
         n_rd++;
         check("rd_addr_at_strobe", 64'(rd_addr), 64'(exp_rd_addr));
      end
      if (sd_start) n_sd++;
      if (cmd_err)  n_err++;
      if (chk_req != chk_seen) begin
         chk_seen = chk_req;
         check("wr_en_count",  64'(n_wr - b_wr),   64'(exp_wr));
         check("rd_en_count",  64'(n_rd - b_rd),   64'(exp_rd));
         check("sd_start_count", 64'(n_sd - b_sd), 64'(exp_sd));
         check("cmd_err_count", 64'(n_err - b_err), 64'(exp_err));
         check("state_idle",   64'(spi_state),     64'd0);
         check("bounded_wait", 64'(timeout_flag),  64'd0);
         if (exp_rx_valid)   check("miso_word_model", 64'(rx_words[2]), 64'(exp_rx));
         if (lit_rx_valid)   check("miso_word_lit",   64'(rx_words[2]), 64'(lit_rx));
         if (lit_hold_valid) begin
            check("wr_addr_hold", 64'(wr_addr), 64'(lit_wr_addr));
            check("wr_data_hold", 64'(wr_data), 64'(lit_wr_data));
         end
         b_wr = n_wr; b_rd = n_rd; b_sd = n_sd; b_err = n_err;
      end
      if (done) begin
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   // Frame-level model: what strobes a frame must produce
   task automatic predict(input logic [15:0] w0, w1, w2, input int nwords, input int lastbits);
      int full;
      full = nwords - 1 + ((lastbits == 16) ? 1 : 0);
      exp_wr = 0; exp_rd = 0; exp_sd = 0; exp_err = 0;
      exp_rx_valid = 1'b0;
      lit_rx_valid = 1'b0;
      lit_hold_valid = 1'b0;
      exp_wr_addr = w1; exp_wr_data = w2; exp_rd_addr = w1;
      exp_rx = mem[w1[7:0]];
      quiet = (w0 != 16'd3);
      if (full == 0) exp_err = 1;
      else if (w0 == 16'd2) begin
         if (full == 3) exp_wr = 1; else exp_err = 1;
      end else if (w0 == 16'd3) begin
         if (full >= 2) exp_rd = 1;
         if (full < 3) exp_err = 1; else exp_rx_valid = 1'b1;
      end else if (w0 == 16'd5) exp_sd = 1;
      else exp_err = 1;
   endtask

   // SPI mode-0 master: drive on sck low, sample MISO at each rise
   task automatic send_frame(input logic [15:0] w0, w1, w2, input int nwords, input int lastbits);
      logic [15:0] w;
      int nb;
      for (int i = 0; i < 3; i++) rx_words[i] = 16'h0;
      fc_spi_ss_p = 1'b0;
      repeat (HALF) @(negedge clk210_p);
      for (int wi = 0; wi < nwords; wi++) begin
         w  = (wi == 0) ? w0 : (wi == 1) ? w1 : w2;
         nb = (wi == nwords - 1) ? lastbits : 16;
         for (int b = 0; b < nb; b++) begin
            fc_spi_mosi_p = w[15-b];
            repeat (HALF) @(negedge clk210_p);
            fc_spi_sck_p = 1'b1;
            rx_words[wi][15-b] = fc_spi_miso_p;
            repeat (HALF) @(negedge clk210_p);
            fc_spi_sck_p = 1'b0;
         end
      end
      repeat (HALF) @(negedge clk210_p);
      fc_spi_ss_p   = 1'b1;
      fc_spi_mosi_p = 1'b0;
      repeat (12) @(negedge clk210_p);
   endtask

   task automatic request_check();
      chk_req++;
      repeat (3) @(negedge clk210_p);
   endtask

   task automatic run_frame(input logic [15:0] w0, w1, w2, input int nwords, input int lastbits);
      predict(w0, w1, w2, nwords, lastbits);
      send_frame(w0, w1, w2, nwords, lastbits);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h3C5A;
      mem[8'h20] = 16'hBEEF;
      mem[8'h54] = 16'h5A3C;
      reset_p = 1'b0; fc_spi_sck_p = 1'b0; fc_spi_mosi_p = 1'b0; fc_spi_ss_p = 1'b1;
      exp_wr = 0; exp_rd = 0; exp_sd = 0; exp_err = 0;
      exp_wr_addr = 0; exp_wr_data = 0; exp_rd_addr = 0; exp_rx = 0;
      exp_rx_valid = 0; lit_rx_valid = 0; lit_hold_valid = 0;
      lit_rx = 0; lit_wr_addr = 0; lit_wr_data = 0;
      quiet = 1'b1; timeout_flag = 1'b0; done = 1'b0; chk_req = 0;

      // Reset state
      repeat (5) @(negedge clk210_p);
      reset_p = 1'b1;
      repeat (10) @(negedge clk210_p);
      lit_hold_valid = 1'b1; lit_wr_addr = 16'h0; lit_wr_data = 16'h0;
      request_check();

      // Write
      run_frame(16'h0002, 16'h0050, 16'h0011, 3, 16);
      lit_hold_valid = 1'b1; lit_wr_addr = 16'h0050; lit_wr_data = 16'h0011;
      request_check();

      // Read
      run_frame(16'h0003, 16'h0020, 16'h0000, 3, 16);
      lit_rx_valid = 1'b1; lit_rx = 16'hBEEF;
      request_check();

      // SD read start
      run_frame(16'h0005, 16'h0000, 16'h0000, 1, 16);
      request_check();

      // Unknown command, second word ignored
      run_frame(16'h0007, 16'h1234, 16'h0000, 2, 16);
      request_check();

      // Abort after 8 bits of word2, then a clean write
      run_frame(16'h0002, 16'h0052, 16'h0077, 3, 8);
      request_check();
      run_frame(16'h0002, 16'h0051, 16'h00A5, 3, 16);
      lit_hold_valid = 1'b1; lit_wr_addr = 16'h0051; lit_wr_data = 16'h00A5;
      request_check();

      // Reset during RD_DATA; rd_en was already issued
      predict(16'h0003, 16'h0020, 16'h0000, 3, 16);
      exp_rx_valid = 1'b0;
      fork
         send_frame(16'h0003, 16'h0020, 16'h0000, 3, 16);
         begin
            int k;
            k = 0;
            while (spi_state != 8'd4 && k < 3000) begin
               @(negedge clk210_p);
               k++;
            end
            if (k >= 3000) timeout_flag = 1'b1;
            repeat (40) @(negedge clk210_p);
            reset_p = 1'b0;
            repeat (4) @(negedge clk210_p);
            reset_p = 1'b1;
         end
      join
      request_check();

      // Read after reset recovery
      run_frame(16'h0003, 16'h0054, 16'h0000, 3, 16);
      lit_rx_valid = 1'b1; lit_rx = 16'h5A3C;
      request_check();

      done = 1'b1;
      repeat (5) @(negedge clk210_p);
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/fc_spi_slave.md
Name: fc_spi_slave

Overview:
- Flight-computer SPI responder inside the FPGA top, on the fc_spi_* pins; the BBB acts as the SPI master.
- Deserialises 16-bit command/address/data words from the master.
- Issues single-cycle write/read strobes to the memory map and serialises read data back on MISO.
- Raises a start pulse for the SD-card read command.

Parameters:
- WORD_W, 16, bits per SPI word and per memory-map address/data.
- RD_LATENCY, 1, clk cycles from memory_map_spi_rd_en_p to valid memory_map_spi_rd_data_p.
- SYNC_STAGES, 2, flip-flop stages synchronising sck/mosi/ss into the clk domain.

Ports:
- clk210_p  in  1  system clock.
- reset_p  in  1  asynchronous reset, active-low.
- fc_spi_sck_p  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- fc_spi_mosi_p  in  1  master-to-slave data, MSB first.
- fc_spi_ss_p  in  1  slave select, active-low.
- fc_spi_miso_p  out  1  slave-to-master data.
- memory_map_spi_wr_addr_p  out  16  write address.
- memory_map_spi_wr_data_p  out  16  write data.
- memory_map_spi_wr_en_p  out  1  one-cycle write strobe.
- memory_map_spi_rd_addr_p  out  16  read address.
- memory_map_spi_rd_en_p  out  1  one-cycle read strobe.
- memory_map_spi_rd_data_p  in  16  read data, valid RD_LATENCY cycles after rd_en.
- sd_read_start_p  out  1  one-cycle pulse on command 5.
- cmd_error_p  out  1  one-cycle pulse on unknown command or aborted frame.
- spi_state_p  out  8  current FSM state encoding, zero-extended.

Behaviour:
- Reset (reset_p=0, async) sets all outputs to 0 and the FSM to IDLE. On reset release, activity starts only at the next ss falling edge.
- sck, mosi and ss each pass through SYNC_STAGES flops; rise/fall of sck and ss are edge-detected in clk210_p.
- Required SCK period is ≥ 2*(SYNC_STAGES+RD_LATENCY+3) clk periods; faster SCK is outside specification.
- Bit counter 0..15 samples mosi on each detected sck rise. The word completes on the 16th rise, then the counter wraps to 0.
- Frame format: word0 = command; word1 = address; word2 = data (write) or dummy (read).
- FSM states: IDLE=0, CMD=1, ADDR=2, WR_DATA=3, RD_DATA=4, WAIT_SS=5.
- IDLE: ss fall -> CMD, bit counter cleared.
- CMD, word complete:
  - 2 -> ADDR (write).
  - 3 -> ADDR (read).
  - 5 -> sd_read_start_p pulse next cycle, -> WAIT_SS.
  - any other value -> cmd_error_p pulse, -> WAIT_SS.
- ADDR, word complete:
  - write: latch wr_addr, -> WR_DATA.
  - read: latch rd_addr and pulse rd_en the next cycle. Capture rd_data into the tx shift register exactly RD_LATENCY cycles after rd_en. -> RD_DATA.
- WR_DATA, word complete: latch wr_data and pulse wr_en in the same cycle as the data latch, one cycle after the 16th rise. -> WAIT_SS.
- RD_DATA: each detected sck fall drives miso <= tx[15] and shifts tx left by one.
  - The first fall after word1's 16th rise presents bit 15.
  - Word complete -> WAIT_SS.
- WAIT_SS: further sck edges are ignored and miso=0; ss rise -> IDLE.
- miso is 0 whenever ss is high or the state is not RD_DATA.
- ss rise in CMD/ADDR/WR_DATA/RD_DATA before the frame completes: abort. No wr_en, pulse cmd_error_p, -> IDLE. rd_en already issued is not retracted.
- ss rise and a word-complete in the same clk cycle: the word completion takes effect first, then the FSM goes to IDLE.
- wr_addr, wr_data and rd_addr hold their last latched values until the next latch.
- At most one of wr_en, rd_en, sd_read_start_p, cmd_error_p is high in any cycle.

Decomposition:
- Package fc_spi_pkg holds:
  - CMD_WRITE=16'd2, CMD_READ=16'd3, CMD_SD_READ=16'd5.
  - The FSM state enumeration, WORD_W default.
- Sub-module fc_spi_sync_edge (parameter SYNC_STAGES): synchroniser plus rise/fall detect. Instantiate it for sck and ss, and as a plain synchroniser for mosi.

Test Plan:
- Write: frame {0x0002, 0x0050, 0x0011} -> one wr_en pulse with wr_addr=0x0050, wr_data=0x0011; no rd_en; spi_state_p returns to 0 after ss rise.
- Read: frame {0x0003, 0x0020, 0x0000}, memory model returns 0xBEEF at RD_LATENCY=1 -> exactly one rd_en with rd_addr=0x0020; master captures 0xBEEF on word2.
- SD command: frame {0x0005} -> one sd_read_start_p pulse; no wr_en/rd_en; miso stays 0.
- Unknown command: frame {0x0007, 0x1234} -> one cmd_error_p pulse, no strobes, second word ignored.
- Abort: write frame with ss raised after 8 bits of word2 -> no wr_en, one cmd_error_p, state IDLE; a following full write to 0x0051 succeeds.
- Reset mid-read: reset_p low during RD_DATA -> all outputs 0 immediately; after release, a read of 0x0054 returns correct data.
